// File: rtl/ram_sp_init_pkg.sv
// Shared types and helpers for the single-port RAM family.
// Holds the controller state encoding and the byte-lane arithmetic.
package ram_sp_init_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } ram_state_e;

   localparam int BYTE_W = 8;

   function automatic int lane_count(input int data_w);
      return data_w / BYTE_W;
   endfunction

endpackage

// File: rtl/ram_sp_init_core.sv
// Byte-lane-writable storage array with a registered read port.
// The array and read register carry no reset; the controller clears the contents.
module ram_sp_init_core
   import ram_sp_init_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic                          clk_i,
   input  logic [lane_count(DATA_W)-1:0] we_i,
   input  logic                          re_i,
   input  logic [ADDR_W-1:0]             addr_i,
   input  logic [DATA_W-1:0]             wdata_i,
   output logic [DATA_W-1:0]             rdata_o
);

   localparam int LANES = lane_count(DATA_W);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < LANES; k++) begin
         if (we_i[k]) begin
            mem[addr_i][k*BYTE_W +: BYTE_W] <= wdata_i[k*BYTE_W +: BYTE_W];
         end
      end
      if (re_i) begin
         rdata_q <= mem[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_sp_init.sv
// Single-port RAM controller: post-reset clearing sweep, request decode,
// one-cycle error pulse and the tri-state read-data driver.
module ram_sp_init
   import ram_sp_init_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 8,
   parameter bit                INIT_EN  = 1'b1,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          wr_en_i,
   input  logic                          rd_en_i,
   input  logic [ADDR_W-1:0]             addr_i,
   input  logic [lane_count(DATA_W)-1:0] be_i,
   inout  wire  [DATA_W-1:0]             data_io,
   output logic                          rd_valid_o,
   output logic                          busy_o,
   output logic                          err_o,
   output ram_state_e                    dbg_state_o
);

   localparam int LANES = lane_count(DATA_W);

   if (DATA_W % BYTE_W != 0) begin : g_width_check
      $error("ram_sp_init: DATA_W must be a multiple of 8");
   end

   ram_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic              rd_valid_q, rd_valid_d;
   logic              err_q, err_d;

   logic [LANES-1:0]  core_we;
   logic              core_re;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_rdata;
   logic              drive_en;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= INIT_EN ? ST_INIT : ST_IDLE;
         clr_addr_q <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      rd_valid_d = 1'b0;
      err_d      = 1'b0;
      core_we    = '0;
      core_re    = 1'b0;
      core_addr  = addr_i;
      core_wdata = data_io;
      case (state_q)
         ST_INIT: begin
            core_we    = '1;
            core_addr  = clr_addr_q;
            core_wdata = INIT_VAL;
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            err_d      = wr_en_i | rd_en_i;
            if (clr_addr_q == '1) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            // A simultaneous read and write is rejected outright; memory is untouched.
            if (wr_en_i && rd_en_i) begin
               err_d = 1'b1;
            end else if (wr_en_i) begin
               core_we = be_i;
               err_d   = rd_valid_q;
            end else if (rd_en_i) begin
               core_re    = 1'b1;
               rd_valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (!rst_n_i) begin
         core_we = '0;
         core_re = 1'b0;
      end
   end

   ram_sp_init_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk_i   (clk_i),
      .we_i    (core_we),
      .re_i    (core_re),
      .addr_i  (core_addr),
      .wdata_i (core_wdata),
      .rdata_o (core_rdata)
   );

   // rd_valid_o is a one-cycle qualifier with no back-pressure: data_io holds read
   // data only in that cycle, and a master write in that cycle takes the bus back.
   assign drive_en    = rd_valid_q & ~wr_en_i;
   assign data_io     = drive_en ? core_rdata : 'z;
   assign rd_valid_o  = rd_valid_q;
   assign busy_o      = (state_q == ST_INIT);
   assign err_o       = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_sp_init.sv
// Self-checking bench for ram_sp_init: clearing sweep, byte lanes, collisions,
// bus hand-back, resets mid-sweep and mid-read, and the no-clear variant.
module tb_ram_sp_init;
   import ram_sp_init_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0, drv_en = 1'b0;
   logic [7:0]  addr = '0;
   logic [3:0]  be = '0;
   logic [31:0] drv = '0;
   wire  [31:0] data_io;
   logic        rd_valid, busy, err;
   ram_state_e  dbg_state;

   logic        rst_n2 = 1'b0, wr_en2 = 1'b0, rd_en2 = 1'b0, drv_en2 = 1'b0;
   logic [7:0]  addr2 = '0;
   logic [3:0]  be2 = '0;
   logic [31:0] drv2 = '0;
   wire  [31:0] data_io2;
   logic        rd_valid2, busy2, err2;
   ram_state_e  dbg_state2;

   assign data_io  = drv_en  ? drv  : 'z;
   assign data_io2 = drv_en2 ? drv2 : 'z;

   ram_sp_init #(.DATA_W(32), .ADDR_W(8), .INIT_EN(1'b1), .INIT_VAL(32'h0)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .rd_en_i(rd_en), .addr_i(addr),
      .be_i(be), .data_io(data_io), .rd_valid_o(rd_valid), .busy_o(busy), .err_o(err),
      .dbg_state_o(dbg_state)
   );

   ram_sp_init #(.DATA_W(32), .ADDR_W(8), .INIT_EN(1'b0), .INIT_VAL(32'h0)) dut2 (
      .clk_i(clk), .rst_n_i(rst_n2), .wr_en_i(wr_en2), .rd_en_i(rd_en2), .addr_i(addr2),
      .be_i(be2), .data_io(data_io2), .rd_valid_o(rd_valid2), .busy_o(busy2), .err_o(err2),
      .dbg_state_o(dbg_state2)
   );

   // ---------------- scoreboard ----------------
   int          tests_run = 0;
   int          tests_failed = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model [256];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rd_valid && !wr_en) begin
         check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("sb_rdata", data_io, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 256; i++) model[i] = 32'h0;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
      if (rd_valid) tick();
      addr = a; be = b; drv = d; drv_en = 1'b1; wr_en = 1'b1;
      tick();
      wr_en = 1'b0; drv_en = 1'b0;
      for (int k = 0; k < 4; k++) if (b[k]) model[a][k*8 +: 8] = d[k*8 +: 8];
   endtask

   task automatic do_read(input logic [7:0] a);
      addr = a; rd_en = 1'b1;
      exp_q.push_back(model[a]);
      tick();
      rd_en = 1'b0;
   endtask

   // Counts cycles with busy high from the current sample point; optionally
   // pokes a read request mid-sweep to provoke the error pulse.
   task automatic count_busy(input bit inject, output int n);
      n = 0;
      while (busy && n < 1000) begin
         if (inject && n == 11) begin
            check("init_err", err, 1'b1);
            check("init_no_valid", rd_valid, 1'b0);
            rd_en = 1'b0;
         end
         if (inject && n == 12) check("init_err_clr", err, 1'b0);
         if (inject && n == 10) begin
            addr = 8'd3; rd_en = 1'b1;
         end
         n++;
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit expired");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   int          n;
   logic [31:0] vals [4];
   logic [7:0]  addrs [4];
   logic [31:0] d;

   initial begin
      clear_model();
      rst_n = 1'b0;
      tick(); tick(); tick();
      check("rst_busy", busy, 1'b1);
      check("rst_valid", rd_valid, 1'b0);
      check("rst_err", err, 1'b0);
      rst_n = 1'b1;
      count_busy(1'b0, n);
      check("busy_len", n, 256);

      // Dirty a few words, then reset and sweep again: they must read back cleared.
      do_write(8'd77, 32'hDEADBEEF, 4'hF);
      do_write(8'd50, 32'hCAFEF00D, 4'hF);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      count_busy(1'b0, n);
      check("busy_len2", n, 256);
      clear_model();
      do_read(8'd77);
      check("rd_valid_1", rd_valid, 1'b1);
      tick();
      check("rd_valid_0", rd_valid, 1'b0);

      // Write/read a spread of addresses, reads back-to-back.
      addrs = '{8'd50, 8'd100, 8'd200, 8'd250};
      vals  = '{32'd250, 32'd500, 32'd1000, 32'd1250};
      for (int i = 0; i < 4; i++) do_write(addrs[i], vals[i], 4'hF);
      for (int i = 0; i < 4; i++) do_read(addrs[i]);
      check("b2b_last", data_io, 32'd1250);
      tick();

      // Byte-lane merge.
      do_write(8'd10, 32'hAABBCCDD, 4'b1111);
      do_write(8'd10, 32'h11223344, 4'b0101);
      do_read(8'd10);
      check("lane_merge", data_io, 32'hAA22CC44);
      tick();

      // be=0 writes nothing and is not an error.
      do_write(8'd6, 32'hFFFFFFFF, 4'b0000);
      check("be0_no_err", err, 1'b0);
      do_read(8'd6);
      tick();

      // Collision: neither op happens.
      do_write(8'd5, 32'h55, 4'hF);
      addr = 8'd5; be = 4'hF; drv = 32'hDEADBEEF; drv_en = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
      tick();
      wr_en = 1'b0; rd_en = 1'b0; drv_en = 1'b0;
      check("coll_err", err, 1'b1);
      check("coll_valid", rd_valid, 1'b0);
      tick();
      check("coll_err_clr", err, 1'b0);
      do_read(8'd5);
      tick();

      // Master write during a read-valid cycle: RAM releases, write lands, error pulses.
      addr = 8'd50; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      addr = 8'd51; be = 4'hF; drv = ~model[50]; drv_en = 1'b1; wr_en = 1'b1;
      #1;
      check("cont_valid", rd_valid, 1'b1);
      check("cont_bus", data_io, ~model[50]);
      tick();
      wr_en = 1'b0; drv_en = 1'b0;
      model[51] = ~model[50];
      check("cont_err", err, 1'b1);
      do_read(8'd51);
      tick();

      // Random mix over a small window.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            do_write(8'(96 + $urandom_range(0, 15)), d, 4'($urandom_range(0, 15)));
         end else begin
            do_read(8'(96 + $urandom_range(0, 15)));
         end
      end
      tick(); tick();

      // Reset in a read's valid cycle kills the read and releases the bus.
      do_read(8'd1);
      check("pre_rst_valid", rd_valid, 1'b1);
      rst_n = 1'b0;
      tick();
      check("rst_kill_valid", rd_valid, 1'b0);
      drv = ~model[1]; drv_en = 1'b1;
      #1;
      check("rst_bus_free", data_io, ~model[1]);
      drv_en = 1'b0;
      rst_n = 1'b1;

      // Reset 100 cycles into the sweep restarts it; also poke a request mid-sweep.
      for (int i = 0; i < 100; i++) tick();
      check("mid_init_busy", busy, 1'b1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      count_busy(1'b1, n);
      check("busy_len3", n, 256);
      clear_model();
      do_read(8'd100);
      tick(); tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      // No-clear variant: idle straight after reset, back-to-back reads.
      rst_n2 = 1'b0;
      tick(); tick();
      rst_n2 = 1'b1;
      check("n_rst_busy", busy2, 1'b0);
      tick();
      check("n_busy_first", busy2, 1'b0);
      vals = '{32'h0, 32'h111, 32'h2222, 32'h33333};
      for (int i = 1; i < 4; i++) begin
         addr2 = 8'(i); be2 = 4'hF; drv2 = vals[i]; drv_en2 = 1'b1; wr_en2 = 1'b1;
         tick();
         wr_en2 = 1'b0; drv_en2 = 1'b0;
      end
      for (int i = 1; i < 4; i++) begin
         addr2 = 8'(i); rd_en2 = 1'b1;
         tick();
         check("n_b2b_valid", rd_valid2, 1'b1);
         check("n_b2b_data", data_io2, vals[i]);
      end
      rd_en2 = 1'b0;
      tick();
      check("n_valid_end", rd_valid2, 1'b0);
      check("n_err", err2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
